ex_mem_pipe: RTL and testbench

EX_MEM_PIPE -- requirements
Module: ex_mem_pipe

---
 rtl/ex_mem_pipe.sv | 124 ++++++++++++
 tb/tb_ex_mem_pipe.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register with branch redirect and wrong-path squash shadow.
// Optional forwarding outputs are enabled by defining EX_MEM_FWD_EN.
module ex_mem_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5,
  parameter int SHADOW     = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ex_valid,
  input  logic [DATA_WIDTH-1:0] ALUResult,
  input  logic [DATA_WIDTH-1:0] RegData2,
  input  logic [REG_ADDR_W-1:0] Rd,
  input  logic                  RegWrite,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic                  Branch,
  input  logic                  Jump,
  input  logic [DATA_WIDTH-1:0] BranchTarget,
  input  logic                  mem_stall,
  output logic                  mem_valid,
  output logic [DATA_WIDTH-1:0] mem_alu_result,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [REG_ADDR_W-1:0] mem_rd,
  output logic                  mem_RegWrite,
  output logic                  mem_MemRead,
  output logic                  mem_MemWrite,
  output logic                  pc_sel,
  output logic [DATA_WIDTH-1:0] pc_target,
  output logic                  ex_hold
`ifdef EX_MEM_FWD_EN
  ,
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_rd,
  output logic [DATA_WIDTH-1:0] fwd_data
`endif
);

  // state  | meaning
  // RUN    | slots pass to MEM, branches evaluated
  // SQUASH | sq_cnt wrong-path slots left to kill after a redirect
  typedef enum logic {RUN, SQUASH} state_t;

  localparam logic [1:0] SHADOW_CNT = 2'(SHADOW);

  state_t     state, state_next;
  logic [1:0] sq_cnt, sq_cnt_next;
  logic       accept, taken;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= RUN;
      sq_cnt <= 2'd0;
    end else begin
      state  <= state_next;
      sq_cnt <= sq_cnt_next;
    end
  end

  always_comb begin
    state_next  = state;
    sq_cnt_next = sq_cnt;
    accept      = ex_valid & ~mem_stall & (state == RUN);
    taken       = accept & ((Branch & ALUResult[0]) | Jump);
    if (!mem_stall) begin
      case (state)
        RUN: begin
          if (taken) begin
            state_next  = SQUASH;
            sq_cnt_next = SHADOW_CNT;
          end
        end
        SQUASH: begin
          // a count of 0 here is unreachable; treat it like the last slot
          if (sq_cnt <= 2'd1) begin
            state_next  = RUN;
            sq_cnt_next = 2'd0;
          end else begin
            sq_cnt_next = sq_cnt - 2'd1;
          end
        end
        default: begin
          state_next  = RUN;
          sq_cnt_next = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_valid      <= 1'b0;
      mem_alu_result <= '0;
      mem_wdata      <= '0;
      mem_rd         <= '0;
      mem_RegWrite   <= 1'b0;
      mem_MemRead    <= 1'b0;
      mem_MemWrite   <= 1'b0;
      pc_sel         <= 1'b0;
      pc_target      <= '0;
    end else begin
      pc_sel <= taken;
      if (taken) pc_target <= BranchTarget;
      if (!mem_stall) begin
        mem_valid      <= accept;
        mem_alu_result <= ALUResult;
        mem_wdata      <= RegData2;
        mem_rd         <= Rd;
        mem_RegWrite   <= accept & RegWrite;
        mem_MemRead    <= accept & MemRead;
        mem_MemWrite   <= accept & MemWrite;
      end
    end
  end

  assign ex_hold = mem_stall;

`ifdef EX_MEM_FWD_EN
  assign fwd_valid = mem_valid & mem_RegWrite & (mem_rd != '0);
  assign fwd_rd    = mem_rd;
  assign fwd_data  = mem_alu_result;
`endif

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Bench for ex_mem_pipe: directed scenarios then random traffic against a
// slot-level reference model (remaining-shadow count, expected MEM contents).
module tb_ex_mem_pipe;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int SH = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          ex_valid;
  logic [DW-1:0] ALUResult, RegData2, BranchTarget;
  logic [AW-1:0] Rd;
  logic          RegWrite, MemRead, MemWrite, Branch, Jump, mem_stall;
  logic          mem_valid, mem_RegWrite, mem_MemRead, mem_MemWrite, pc_sel, ex_hold;
  logic [DW-1:0] mem_alu_result, mem_wdata, pc_target;
  logic [AW-1:0] mem_rd;
`ifdef EX_MEM_FWD_EN
  logic          fwd_valid;
  logic [AW-1:0] fwd_rd;
  logic [DW-1:0] fwd_data;
`endif

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  int            shadow_left;
  logic          e_valid, e_rw, e_mr, e_mw, e_pcsel;
  logic [DW-1:0] e_alu, e_wdata, e_target;
  logic [AW-1:0] e_rd;

  ex_mem_pipe #(.DATA_WIDTH(DW), .REG_ADDR_W(AW), .SHADOW(SH)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ALUResult(ALUResult),
    .RegData2(RegData2), .Rd(Rd), .RegWrite(RegWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .Branch(Branch), .Jump(Jump), .BranchTarget(BranchTarget),
    .mem_stall(mem_stall), .mem_valid(mem_valid), .mem_alu_result(mem_alu_result),
    .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_RegWrite(mem_RegWrite),
    .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite), .pc_sel(pc_sel),
    .pc_target(pc_target), .ex_hold(ex_hold)
`ifdef EX_MEM_FWD_EN
    , .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    shadow_left = 0;
    e_valid = 0; e_rw = 0; e_mr = 0; e_mw = 0; e_pcsel = 0;
    e_alu = '0; e_wdata = '0; e_target = '0; e_rd = '0;
  endtask

  // one clock edge as seen by the specification's slot rules
  task automatic model_edge();
    bit v, tk;
    e_pcsel = 0;
    if (!mem_stall) begin
      v  = ex_valid && (shadow_left == 0);
      tk = v && ((Branch && ALUResult[0]) || Jump);
      e_valid = v;
      e_rw = v && RegWrite; e_mr = v && MemRead; e_mw = v && MemWrite;
      e_alu = ALUResult; e_wdata = RegData2; e_rd = Rd;
      if (shadow_left > 0) shadow_left--;
      else if (tk) begin
        shadow_left = SH;
        e_pcsel = 1;
        e_target = BranchTarget;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".mem_valid"}, 64'(mem_valid), 64'(e_valid));
    chk({tag, ".mem_alu_result"}, 64'(mem_alu_result), 64'(e_alu));
    chk({tag, ".mem_wdata"}, 64'(mem_wdata), 64'(e_wdata));
    chk({tag, ".mem_rd"}, 64'(mem_rd), 64'(e_rd));
    chk({tag, ".mem_ctl"}, 64'({mem_RegWrite, mem_MemRead, mem_MemWrite}),
        64'({e_rw, e_mr, e_mw}));
    chk({tag, ".pc_sel"}, 64'(pc_sel), 64'(e_pcsel));
    if (e_pcsel) chk({tag, ".pc_target"}, 64'(pc_target), 64'(e_target));
    chk({tag, ".ex_hold"}, 64'(ex_hold), 64'(mem_stall));
`ifdef EX_MEM_FWD_EN
    chk({tag, ".fwd_valid"}, 64'(fwd_valid), 64'(e_valid && e_rw && (e_rd != '0)));
    chk({tag, ".fwd_rd"}, 64'(fwd_rd), 64'(e_rd));
    chk({tag, ".fwd_data"}, 64'(fwd_data), 64'(e_alu));
`endif
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] alu, input logic [AW-1:0] rd,
                       input logic rw, input logic mr, input logic mw,
                       input logic br, input logic jmp, input logic [DW-1:0] bt,
                       input logic stall);
    ex_valid = v; ALUResult = alu; RegData2 = $urandom; Rd = rd;
    RegWrite = rw; MemRead = mr; MemWrite = mw; Branch = br; Jump = jmp;
    BranchTarget = bt; mem_stall = stall;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    reset = 1'b0;

    // ADD x5 = 7
    drive(1, 32'h7, 5, 1, 0, 0, 0, 0, 0, 0);
    cycle("add");
    chk("add.value", 64'(mem_alu_result), 64'h7);

    // taken BEQ to 0x40, then shadow of SH slots, then valid stream
    drive(1, 32'h1, 0, 0, 0, 0, 1, 0, 32'h40, 0);
    cycle("beq");
    chk("beq.redirect", 64'({pc_sel, pc_target}), {31'd0, 1'b1, 32'h40});
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h100 + i, 6, 1, 0, 0, 0, 0, 0, 0);
      cycle("beq_shadow");
      chk("beq_shadow.valid", 64'(mem_valid), 64'(i >= SH));
    end

    // not-taken branch keeps the stream valid
    drive(1, 32'h0, 0, 0, 0, 0, 1, 0, 32'h80, 0);
    cycle("bne_nt");
    for (int i = 0; i < 2; i++) begin
      drive(1, 32'h200 + i, 7, 1, 0, 0, 0, 0, 0, 0);
      cycle("nt_stream");
    end

    // jump, then SW held by a 3-cycle stall while in the shadow
    drive(1, 32'h0, 1, 1, 0, 0, 0, 1, 32'hC0, 0);
    cycle("jal");
    chk("jal.regwrite", 64'({mem_valid, mem_RegWrite}), 64'b11);
    drive(1, 32'h44, 0, 0, 0, 1, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cycle("sw_stall");
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h300 + i, 0, 0, 0, 1, 0, 0, 0, 0);
      cycle("sw_release");
    end

    // reset mid-squash with one shadow slot left
    drive(1, 32'h1, 0, 0, 0, 0, 1, 0, 32'h20, 0);
    cycle("beq2");
    drive(1, 32'h55, 8, 1, 0, 0, 0, 0, 0, 0);
    cycle("beq2_sq");
    #3 reset = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    #2 reset = 1'b0;
    drive(1, 32'h66, 9, 1, 0, 0, 0, 0, 0, 0);
    cycle("post_rst");
    chk("post_rst.valid", 64'(mem_valid), 64'd1);

`ifdef EX_MEM_FWD_EN
    drive(1, 32'h77, 0, 1, 0, 0, 0, 0, 0, 0);
    cycle("fwd_rd0");
    chk("fwd_rd0.valid", 64'(fwd_valid), 64'd0);
    drive(1, 32'h78, 3, 1, 0, 0, 0, 0, 0, 0);
    cycle("fwd_rd3");
    chk("fwd_rd3.valid", 64'({fwd_valid, fwd_data}), {31'd0, 1'b1, 32'h78});
`endif

    // random traffic
    for (int i = 0; i < 500; i++) begin
      drive(1'($urandom_range(0, 3) != 0), $urandom, AW'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 9) == 0),
            $urandom, 1'($urandom_range(0, 3) == 0));
      cycle("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
